// File: rtl/ec_pkg.sv
// Shared types and width helpers for the error-compensation accumulator pipe.
// Also holds the 3:2 compressor (full-adder) cell the popcount tree is built from.
package ec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } ec_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int cnt_w(input int err_w);
        return clog2(err_w + 1);
    endfunction

    function automatic int acc_w(input int err_w, input int max_beats);
        return clog2(err_w * max_beats + 2);
    endfunction

    function automatic int beat_w(input int max_beats);
        return clog2(max_beats + 1);
    endfunction

    // 3:2 compressor cell: returns {carry, sum}.
    function automatic logic [1:0] csa32(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/ec_popcnt.sv
// Combinational popcount: a carry-save chain of 3:2 compressor cells folds in one
// error bit per level, then a single carry-propagate adder resolves sum + carry.
module ec_popcnt
    import ec_pkg::*;
#(
    parameter int ERR_W = 8,
    localparam int CNT_W = cnt_w(ERR_W)
) (
    input  logic [ERR_W-1:0] bits,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] sum_v;
    logic [CNT_W-1:0] car_v;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] sm;
    logic [CNT_W-1:0] cy;

    // The running total always fits CNT_W, so the carry shifted out of the MSB is zero.
    always_comb begin
        sum_v = '0;
        car_v = '0;
        x     = '0;
        sm    = '0;
        cy    = '0;
        for (int i = 0; i < ERR_W; i++) begin
            x    = '0;
            x[0] = bits[i];
            for (int b = 0; b < CNT_W; b++) begin
                {cy[b], sm[b]} = csa32(sum_v[b], car_v[b], x[b]);
            end
            sum_v = sm;
            car_v = {cy[CNT_W-2:0], 1'b0};
        end
        cnt = sum_v + car_v;
    end

endmodule

// File: rtl/ec_acc_pipe.sv
// Streaming error-compensation accumulator: popcount per beat, sum per group, one result per group.
// Optional macro EC_SAT_EN saturates comp_out on overflow instead of wrapping.
module ec_acc_pipe
    import ec_pkg::*;
#(
    parameter int ERR_W     = 8,
    parameter int MAX_BEATS = 16,
    parameter int OUT_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ERR_W-1:0] err_in,
    input  logic             in_last,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] comp_out,
    output logic             out_ovf,
    output logic             out_forced
);

    localparam int CNT_W  = cnt_w(ERR_W);
    localparam int ACC_W  = acc_w(ERR_W, MAX_BEATS);
    localparam int BEAT_W = beat_w(MAX_BEATS);

    // Handshake rule on both sides: a transfer happens on a rising edge where valid && ready;
    // the source holds its payload stable while valid is high and ready is low.

    ec_state_e state, state_next;
    logic              load_out;
    logic [BEAT_W-1:0] beat_cnt;
    logic              accept, at_max, closing;
    logic [CNT_W-1:0]  pop;
    logic              s1_valid, s1_first, s1_cin, s1_last, s1_forced;
    logic [CNT_W-1:0]  s1_cnt;
    logic [ACC_W-1:0]  acc, acc_next;
    logic [OUT_W-1:0]  comp_next;
    logic              ovf_next;

    ec_popcnt #(.ERR_W(ERR_W)) u_popcnt (
        .bits (err_in),
        .cnt  (pop)
    );

    assign in_ready = rst_n && (state != HOLD) && !(s1_valid && s1_last);
    assign accept   = in_valid && in_ready;
    assign at_max   = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
    assign closing  = in_last || at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_cnt    <= '0;
            s1_first  <= 1'b0;
            s1_cin    <= 1'b0;
            s1_last   <= 1'b0;
            s1_forced <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_cnt    <= pop;
                s1_first  <= (beat_cnt == '0);
                s1_cin    <= cin;
                s1_last   <= closing;
                s1_forced <= !in_last && at_max;
                beat_cnt  <= closing ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    // The first beat of a group restarts the sum, so no explicit clear of acc is needed.
    always_comb begin
        acc_next = (s1_first ? '0 : acc) + ACC_W'(s1_cnt) + ACC_W'(s1_first && s1_cin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (s1_valid) begin
            acc <= acc_next;
        end
    end

    generate
        if (ACC_W > OUT_W) begin : g_ovf
            assign ovf_next = |acc_next[ACC_W-1:OUT_W];
`ifdef EC_SAT_EN
            assign comp_next = ovf_next ? '1 : acc_next[OUT_W-1:0];
`else
            assign comp_next = acc_next[OUT_W-1:0];
`endif
        end else begin : g_no_ovf
            assign ovf_next  = 1'b0;
            assign comp_next = OUT_W'(acc_next);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        case (state)
            IDLE: if (accept) state_next = ACC;
            ACC: begin
                if (s1_valid && s1_last) begin
                    state_next = HOLD;
                    load_out   = 1'b1;
                end
            end
            HOLD: if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            comp_out   <= '0;
            out_ovf    <= 1'b0;
            out_forced <= 1'b0;
        end else if (load_out) begin
            out_valid  <= 1'b1;
            comp_out   <= comp_next;
            out_ovf    <= ovf_next;
            out_forced <= s1_forced;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ec_acc_pipe.sv
// Directed bench for ec_acc_pipe: table of whole groups plus hand-written multi-cycle sequences.
// Expected comp_out follows EC_SAT_EN the same way the design build does.
module tb_ec_acc_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] err_in;
    logic       in_last;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] comp_out;
    logic       out_ovf;
    logic       out_forced;

    int checks;
    int failures;

    ec_acc_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .err_in     (err_in),
        .in_last    (in_last),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .comp_out   (comp_out),
        .out_ovf    (out_ovf),
        .out_forced (out_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]       n;
        logic [15:0][7:0] beats;
        logic             last;
        logic             cin;
        logic [7:0]       sum;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [5:0] exp_comp(input logic [7:0] sum);
`ifdef EC_SAT_EN
        return (sum >= 8'd64) ? 6'h3F : sum[5:0];
`else
        return sum[5:0];
`endif
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input logic [7:0] e, input logic last, input logic c);
        logic ok;
        int   n;
        n        = 0;
        in_valid = 1'b1;
        err_in   = e;
        in_last  = last;
        cin      = c;
        forever begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [5:0] c, output logic o, output logic f);
        int n;
        n         = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("result_arrives", 32'(out_valid), 32'd1);
        c = comp_out;
        o = out_ovf;
        f = out_forced;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t       v;
        logic [5:0] rc;
        logic       ro, rf;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        err_in    = '0;
        in_last   = 1'b0;
        cin       = 1'b0;
        out_ready = 1'b0;

        // Group table: sum is the hand-computed true total including cin.
        v = '0; v.n = 1; v.beats[0] = 8'hFF; v.last = 1; v.cin = 1; v.sum = 9; tbl.push_back(v);
        v = '0; v.n = 4; v.beats[0] = 8'h07; v.beats[1] = 8'h00; v.beats[2] = 8'h81;
        v.beats[3] = 8'hF0; v.last = 1; v.cin = 0; v.sum = 9; tbl.push_back(v);
        v = '0; v.n = 16; for (int i = 0; i < 16; i++) v.beats[i] = 8'hFF;
        v.last = 0; v.cin = 0; v.sum = 128; tbl.push_back(v);
        v = '0; v.n = 3; v.last = 1; v.cin = 0; v.sum = 0; tbl.push_back(v);
        v = '0; v.n = 16; for (int i = 0; i < 16; i++) v.beats[i] = 8'h0F;
        v.last = 1; v.cin = 0; v.sum = 64; tbl.push_back(v);
        v = '0; v.n = 8; for (int i = 0; i < 7; i++) v.beats[i] = 8'hFF;
        v.beats[7] = 8'h7F; v.last = 1; v.cin = 0; v.sum = 63; tbl.push_back(v);
        v = '0; v.n = 2; v.beats[0] = 8'h01; v.beats[1] = 8'hFF; v.last = 1; v.cin = 1;
        v.sum = 10; tbl.push_back(v);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_comp_out", 32'(comp_out), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_out_forced", 32'(out_forced), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single-beat latency: out_valid two cycles after the beat is presented.
        send_beat(8'hFF, 1'b1, 1'b1);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_comp", 32'(comp_out), 32'd9);
        chk("lat_ovf", 32'(out_ovf), 32'd0);
        chk("lat_forced", 32'(out_forced), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("lat_drop", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // in_ready stays low from the closing beat until the result handshake.
        send_beat(8'h07, 1'b0, 1'b0);
        send_beat(8'h00, 1'b0, 1'b0);
        send_beat(8'h81, 1'b0, 1'b0);
        send_beat(8'hF0, 1'b1, 1'b0);
        out_ready = 1'b1;
        chk("blk_rdy_s1", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("blk_valid", 32'(out_valid), 32'd1);
        chk("blk_rdy_hold", 32'(in_ready), 32'd0);
        chk("blk_comp", 32'(comp_out), 32'd9);
        @(posedge clk);
        #1;
        chk("blk_rdy_after", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Table-driven groups; cin is inverted after the first beat to show it is ignored.
        for (int k = 0; k < tbl.size(); k++) begin
            v = tbl[k];
            for (int i = 0; i < int'(v.n); i++) begin
                send_beat(v.beats[i], v.last && (i == int'(v.n) - 1), (i == 0) ? v.cin : !v.cin);
            end
            wait_result(rc, ro, rf);
            chk($sformatf("tbl%0d_comp", k), 32'(rc), 32'(exp_comp(v.sum)));
            chk($sformatf("tbl%0d_ovf", k), 32'(ro), 32'(v.sum >= 8'd64));
            chk($sformatf("tbl%0d_forced", k), 32'(rf), 32'(!v.last));
        end

        // Stalled result: held stable, no new beat accepted.
        send_beat(8'h1F, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        err_in   = 8'h01;
        in_last  = 1'b1;
        cin      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_comp", i), 32'(comp_out), 32'd5);
            chk($sformatf("stall%0d_rdy", i), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall_release_valid", 32'(out_valid), 32'd0);
        chk("stall_release_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(rc, ro, rf);
        chk("stall_next_comp", 32'(rc), 32'd1);

        // Gaps in in_valid (1,0,0,1,1) leave the accumulator untouched.
        send_beat(8'hFF, 1'b0, 1'b1);
        err_in = 8'hFF;
        cin    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_beat(8'h03, 1'b0, 1'b1);
        send_beat(8'h81, 1'b1, 1'b1);
        wait_result(rc, ro, rf);
        chk("gap_comp", 32'(rc), 32'd13);
        chk("gap_ovf", 32'(ro), 32'd0);

        // Reset mid-group discards the partial sum.
        send_beat(8'hFF, 1'b0, 1'b1);
        send_beat(8'hFF, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", 32'(in_ready), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("midrst_quiet%0d", i), 32'(out_valid), 32'd0);
        end
        send_beat(8'h03, 1'b1, 1'b0);
        wait_result(rc, ro, rf);
        chk("midrst_comp", 32'(rc), 32'd2);
        chk("midrst_ovf", 32'(ro), 32'd0);
        chk("midrst_forced", 32'(rf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
